vscpu_mem_arbiter: RTL and testbench
====================================

# vscpu_mem_arbiter

Single-port program/data memory plus arbiter for the vscpu core. Three requesters share one MEMSIZE x D_WIDTH array: the host loader (read/write), the CPU instruction-fetch port and the CPU data-read port. A post-reset clear sequencer zeroes the array before any grant is issued. Host requests take priority, backed by a starvation guard. The CPU ports alternate round-robin.

## Interface
- A_WIDTH, 6, address width
- D_WIDTH, 8, data width
- MEMSIZE, 64, number of words; must equal 1<<A_WIDTH
- STARVE_MAX, 4, consecutive host grants allowed while a CPU port is waiting (>=1)

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- ready  out  1  high while in ST_RUN; no grants are issued while low
- host_req  in  1  host access request, level
- host_we  in  1  1 = write, 0 = read; sampled with host_req
- host_addr  in  A_WIDTH  host address
- host_wdata  in  D_WIDTH  host write data
- host_gnt  out  1  combinational; access accepted this cycle
- host_rdata  out  D_WIDTH  registered read data
- host_rvalid  out  1  one-cycle pulse; host_rdata valid
- if_req  in  1  instruction-fetch request, level, read-only
- if_addr  in  A_WIDTH  fetch address
- if_gnt  out  1  combinational grant
- if_rdata  out  D_WIDTH  registered fetch data
- if_rvalid  out  1  one-cycle pulse
- dm_req  in  1  data-read request, level, read-only
- dm_addr  in  A_WIDTH  data address
- dm_gnt  out  1  combinational grant
- dm_rdata  out  D_WIDTH  registered read data
- dm_rvalid  out  1  one-cycle pulse

## Operation
- FSM states: ST_CLEAR, ST_RUN.
- Reset: state = ST_CLEAR, clr_addr = 0, starve_cnt = 0, rr_ptr = IF. All *_rvalid = 0, all *_rdata = 0, ready = 0.
- ST_CLEAR writes 0 to mem[clr_addr] and increments clr_addr each cycle. After writing MEMSIZE-1 it moves to ST_RUN. All grants stay 0.
- ST_RUN: at most one grant per cycle, following these priority rules:
  - If host_req and starve_cnt < STARVE_MAX, grant the host.
  - Otherwise, if one CPU port is requesting, grant it.
  - If both CPU ports are requesting, grant the one selected by rr_ptr.
  - If starve_cnt == STARVE_MAX and no CPU port is requesting, the host is granted anyway.
- rr_ptr flips to the other CPU port after every CPU grant. It is unchanged by host grants.
- starve_cnt:
  - Increments on a host grant while (if_req | dm_req).
  - Clears to 0 on any CPU grant, or in any cycle where if_req and dm_req are both low.
  - Saturates at STARVE_MAX.
- Granted write: mem[host_addr] <= host_wdata at the edge ending the grant cycle. No rvalid is produced.
- Granted read: the port's rdata <= mem[addr] at the edge ending the grant cycle, and that port's rvalid is high for exactly the following cycle.
- rdata holds its last value until the next read for that port.
- Requesters hold req, addr, we and wdata stable until they see gnt. A requester may drop req, or present a new request, in the cycle after gnt.
- A request without gnt has no side effects.

## Timing
- Read latency: gnt in cycle N gives rvalid and data in cycle N+1.
- Throughput: one access per cycle, back-to-back.
- Write in cycle N followed by a read of the same address in cycle N+1 returns the new data.
- ready rises exactly MEMSIZE cycles after the first rising edge with reset low.
- Reset asserted mid-operation, at edge E:
  - All rvalid outputs are 0 in the cycle after E.
  - Any in-flight read is discarded.
  - The clear sequence restarts from address 0.
  - Writes granted before E are later overwritten by the clear.
- host_req asserted during ST_CLEAR: no grant until ready is high.
- Addresses are used as given. A_WIDTH bits index MEMSIZE words exactly, so no wrap logic is needed.

## Test plan
- Clear sequence: host writes 8'hFF to all addresses, then pulse reset and wait for ready. Host reads of addresses 0, 31 and 63 return 8'h00. ready rises exactly 64 cycles after reset deasserts.
- Write/read: host writes 8'h27 to address 5, then reads address 5 in the next cycle. host_gnt is 1 in both cycles and host_rvalid is 1 in cycle 3 with host_rdata = 8'h27.
- Round-robin: if_req and dm_req held high for 6 cycles, host idle. Grants go IF, DM, IF, DM, IF, DM, and each rvalid follows its gnt by one cycle with the correct data.
- Starvation: host_req and if_req held high continuously, STARVE_MAX = 4. Grants repeat the pattern host x4, IF x1. if_rvalid pulses once every 5 cycles.
- Host priority: host_req, if_req and dm_req are raised in the same cycle with starve_cnt = 0. Only host_gnt is 1, and if_gnt and dm_gnt stay 0 that cycle.
- Reset mid-read: if_gnt in cycle N and reset high at the edge ending cycle N. if_rvalid stays 0 in cycle N+1, ready is 0, and the clear sequence restarts.

Source files
------------

// File: rtl/vscpu_mem_arbiter.sv
// Shared single-port program/data memory with host-priority / CPU round-robin arbiter.
// Latency: grants are combinational; read data and rvalid are registered, one cycle after grant.
// Backpressure: requesters hold their request until gnt; no grants while the clear sequencer runs.
module vscpu_mem_arbiter #(
    parameter int A_WIDTH    = 6,
    parameter int D_WIDTH    = 8,
    parameter int MEMSIZE    = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic               clock,
    input  logic               reset,
    output logic               ready,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [A_WIDTH-1:0] host_addr,
    input  logic [D_WIDTH-1:0] host_wdata,
    output logic               host_gnt,
    output logic [D_WIDTH-1:0] host_rdata,
    output logic               host_rvalid,
    input  logic               if_req,
    input  logic [A_WIDTH-1:0] if_addr,
    output logic               if_gnt,
    output logic [D_WIDTH-1:0] if_rdata,
    output logic               if_rvalid,
    input  logic               dm_req,
    input  logic [A_WIDTH-1:0] dm_addr,
    output logic               dm_gnt,
    output logic [D_WIDTH-1:0] dm_rdata,
    output logic               dm_rvalid
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(MEMSIZE - 1);
    localparam logic [SW-1:0]      STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    // rr_ptr: 0 selects the fetch port, 1 selects the data port
    state_t             state_q, state_d;
    logic [A_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [SW-1:0]      starve_cnt_q, starve_cnt_d;
    logic               rr_ptr_q, rr_ptr_d;

    logic [D_WIDTH-1:0] mem [MEMSIZE];

    logic [D_WIDTH-1:0] host_rdata_q, if_rdata_q, dm_rdata_q;
    logic               host_rvalid_q, if_rvalid_q, dm_rvalid_q;

    logic cpu_any;
    logic starve_full;

    assign cpu_any     = if_req | dm_req;
    assign starve_full = (starve_cnt_q >= STARVE_LIM);

    // Next-state, grant selection and arbiter bookkeeping
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        starve_cnt_d = starve_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        host_gnt     = 1'b0;
        if_gnt       = 1'b0;
        dm_gnt       = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + {{(A_WIDTH-1){1'b0}}, 1'b1};
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Host wins unless it has starved a waiting CPU port for too long
                if (host_req && (!starve_full || !cpu_any)) begin
                    host_gnt = 1'b1;
                end else if (if_req && dm_req) begin
                    if_gnt = ~rr_ptr_q;
                    dm_gnt = rr_ptr_q;
                end else begin
                    if_gnt = if_req;
                    dm_gnt = dm_req;
                end
                if (if_gnt || dm_gnt) begin
                    rr_ptr_d     = ~rr_ptr_q;
                    starve_cnt_d = '0;
                end else if (!cpu_any) begin
                    starve_cnt_d = '0;
                end else if (host_gnt && !starve_full) begin
                    starve_cnt_d = starve_cnt_q + SW'(1);
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Control state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            starve_cnt_q <= '0;
            rr_ptr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            starve_cnt_q <= starve_cnt_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    // Array writes: the clear sequencer owns the port until ST_RUN, then host writes
    always_ff @(posedge clock) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_addr_q] <= '0;
        end else if (host_gnt && host_we) begin
            mem[host_addr] <= host_wdata;
        end
    end

    // Registered read data and one-cycle rvalid pulses per port
    always_ff @(posedge clock) begin
        if (reset) begin
            host_rdata_q  <= '0;
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
            host_rvalid_q <= 1'b0;
            if_rvalid_q   <= 1'b0;
            dm_rvalid_q   <= 1'b0;
        end else begin
            host_rvalid_q <= host_gnt & ~host_we;
            if_rvalid_q   <= if_gnt;
            dm_rvalid_q   <= dm_gnt;
            if (host_gnt && !host_we) host_rdata_q <= mem[host_addr];
            if (if_gnt)               if_rdata_q   <= mem[if_addr];
            if (dm_gnt)               dm_rdata_q   <= mem[dm_addr];
        end
    end

    assign ready       = (state_q == ST_RUN);
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign if_rdata    = if_rdata_q;
    assign if_rvalid   = if_rvalid_q;
    assign dm_rdata    = dm_rdata_q;
    assign dm_rvalid   = dm_rvalid_q;

endmodule

// File: tb/tb_vscpu_mem_arbiter.sv
// Testbench for vscpu_mem_arbiter: directed stimulus with a read-response scoreboard.
// Expected read data and arrival cycle are queued per port when a grant is expected.
// A negedge monitor pops and checks each rvalid pulse independently of the stimulus.
module tb_vscpu_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       ready;
    logic       host_req, host_we;
    logic [5:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       if_req;
    logic [5:0] if_addr;
    logic       if_gnt, if_rvalid;
    logic [7:0] if_rdata;
    logic       dm_req;
    logic [5:0] dm_addr;
    logic       dm_gnt, dm_rvalid;
    logic [7:0] dm_rdata;

    always #5 clock = ~clock;

    vscpu_mem_arbiter #(.A_WIDTH(6), .D_WIDTH(8), .MEMSIZE(64), .STARVE_MAX(4)) dut (
        .clock(clock), .reset(reset), .ready(ready),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .dm_req(dm_req), .dm_addr(dm_addr), .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid)
    );

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t hq[$];
    exp_t iq[$];
    exp_t dq[$];

    logic [7:0] model [64];
    int cyc_cnt = 0;
    int n_checks = 0;
    int n_pass = 0;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    // Scoreboard monitor: every rvalid pulse must match the oldest queued expectation
    always @(negedge clock) begin
        exp_t e;
        if (host_rvalid === 1'b1) begin
            if (hq.size() == 0) chk("host_rvalid_unexpected", 1, 0);
            else begin
                e = hq.pop_front();
                chk("host_rdata", {24'd0, host_rdata}, {24'd0, e.d});
                chk("host_rvalid_cycle", cyc_cnt, e.c);
            end
        end
        if (if_rvalid === 1'b1) begin
            if (iq.size() == 0) chk("if_rvalid_unexpected", 1, 0);
            else begin
                e = iq.pop_front();
                chk("if_rdata", {24'd0, if_rdata}, {24'd0, e.d});
                chk("if_rvalid_cycle", cyc_cnt, e.c);
            end
        end
        if (dm_rvalid === 1'b1) begin
            if (dq.size() == 0) chk("dm_rvalid_unexpected", 1, 0);
            else begin
                e = dq.pop_front();
                chk("dm_rdata", {24'd0, dm_rdata}, {24'd0, e.d});
                chk("dm_rvalid_cycle", cyc_cnt, e.c);
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clock); #1;
        host_req = 1'b0; if_req = 1'b0; dm_req = 1'b0; host_we = 1'b0;
    endtask

    // One host access per cycle; the host is expected to be granted
    task automatic host_cycle(input logic we, input logic [5:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clock);
        chk("host_gnt", {31'd0, host_gnt}, 1);
        if (we) model[a] = d;
        else hq.push_back('{d: model[a], c: cyc_cnt + 1});
    endtask

    // Reset has just been released before the next edge: count edges until ready,
    // keeping host_req high to confirm no grant leaks out of the clear phase
    task automatic wait_ready(input string nm);
        int n = 0;
        int leaks = 0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 6'd9; host_wdata = 8'hA5;
        while (n < 200) begin
            @(posedge clock); #1;
            n++;
            if (ready === 1'b1) break;
            if (host_gnt !== 1'b0 || if_gnt !== 1'b0 || dm_gnt !== 1'b0) leaks++;
        end
        host_req = 1'b0;
        chk(nm, n, 64);
        chk("no_grant_during_clear", leaks, 0);
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset = 1'b1; host_req = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        chk("ready_in_reset", {31'd0, ready}, 0);
        chk("rvalids_in_reset", {29'd0, host_rvalid, if_rvalid, dm_rvalid}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        wait_ready("ready_latency");
    endtask

    initial begin
        reset = 1'b1;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_addr = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_ready", {31'd0, ready}, 0);
        chk("reset_rvalids", {29'd0, host_rvalid, if_rvalid, dm_rvalid}, 0);
        chk("reset_rdatas", {8'd0, host_rdata, if_rdata, dm_rdata}, 0);
        chk("reset_grants", {29'd0, host_gnt, if_gnt, dm_gnt}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        wait_ready("ready_latency_initial");

        // Fill with FF, confirm, then reset and confirm the clear
        for (int i = 0; i < 64; i++) host_cycle(1'b1, 6'(i), 8'hFF);
        host_cycle(1'b0, 6'd7, 8'h00);
        idle_cycle();
        pulse_reset();
        host_cycle(1'b0, 6'd0, 8'h00);
        host_cycle(1'b0, 6'd31, 8'h00);
        host_cycle(1'b0, 6'd63, 8'h00);
        idle_cycle();

        // Write then read-after-write back to back
        host_cycle(1'b1, 6'd5, 8'h27);
        host_cycle(1'b0, 6'd5, 8'h00);
        idle_cycle();

        // Distinct pattern in addresses 0..7
        for (int i = 0; i < 8; i++) host_cycle(1'b1, 6'(i), 8'(8'h10 + i));
        idle_cycle();

        // Round-robin between fetch and data ports, host idle
        if_addr = 6'd0; dm_addr = 6'd1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if_req = 1'b1; dm_req = 1'b1; host_req = 1'b0;
            if (i > 0) begin
                if ((i - 1) % 2 == 0) if_addr = 6'(i + 1);
                else dm_addr = 6'(i + 1);
            end
            @(negedge clock);
            chk("rr_grants", {29'd0, host_gnt, if_gnt, dm_gnt}, (i % 2 == 0) ? 3'b010 : 3'b001);
            if (i % 2 == 0) iq.push_back('{d: model[i], c: cyc_cnt + 1});
            else dq.push_back('{d: model[i], c: cyc_cnt + 1});
        end
        idle_cycle();
        idle_cycle();

        // Starvation guard: host x4 then fetch x1, repeating
        if_addr = 6'd2; host_addr = 6'd5; host_we = 1'b0;
        for (int j = 0; j < 15; j++) begin
            @(posedge clock); #1;
            host_req = 1'b1; host_we = 1'b0; if_req = 1'b1; dm_req = 1'b0;
            @(negedge clock);
            chk("starve_grants", {29'd0, host_gnt, if_gnt, dm_gnt}, (j % 5 < 4) ? 3'b100 : 3'b010);
            if (j % 5 < 4) hq.push_back('{d: model[5], c: cyc_cnt + 1});
            else iq.push_back('{d: model[2], c: cyc_cnt + 1});
        end
        idle_cycle();
        idle_cycle();

        // Host priority with all three requesting and a fresh starvation count
        @(posedge clock); #1;
        host_req = 1'b1; host_we = 1'b0; host_addr = 6'd3; if_req = 1'b1; dm_req = 1'b1;
        if_addr = 6'd4; dm_addr = 6'd6;
        @(negedge clock);
        chk("priority_grants", {29'd0, host_gnt, if_gnt, dm_gnt}, 3'b100);
        hq.push_back('{d: model[3], c: cyc_cnt + 1});
        idle_cycle();
        idle_cycle();

        // Reset lands on the edge ending a fetch grant: the read is discarded
        @(posedge clock); #1;
        if_req = 1'b1; if_addr = 6'd2;
        @(negedge clock);
        chk("midreset_if_gnt", {31'd0, if_gnt}, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        if_req = 1'b0;
        @(negedge clock);
        chk("midreset_if_rvalid", {31'd0, if_rvalid}, 0);
        chk("midreset_ready", {31'd0, ready}, 0);
        chk("midreset_if_rdata", {24'd0, if_rdata}, 0);
        reset = 1'b0;
        wait_ready("ready_latency_midreset");
        host_cycle(1'b0, 6'd5, 8'h00);
        host_cycle(1'b0, 6'd2, 8'h00);
        idle_cycle();
        repeat (3) @(posedge clock);
        @(negedge clock);

        chk("host_queue_drained", hq.size(), 0);
        chk("if_queue_drained", iq.size(), 0);
        chk("dm_queue_drained", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
